instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  in  1  rising-edge clock shared with PC register.
REQ-002 rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-003 pc_cur  in  32  current PC from PC register output.
REQ-004 pc_next  out  32  next PC value to PC register data input.
REQ-005 pc_ena  out  1  PC register load enable.
REQ-006 imem_req  out  1  instruction memory request.
REQ-007 imem_addr  out  32  request address.
REQ-008 imem_gnt  in  1  memory accepts request this cycle.
REQ-009 imem_rvalid  in  1  read data valid.
REQ-010 imem_rdata  in  32  read data.
REQ-011 redirect  in  1  branch/jump/exception redirect pulse.
REQ-012 redirect_pc  in  32  redirect target.
REQ-013 inst_valid  out  1  buffered instruction available to decode.
REQ-014 inst_ready  in  1  decode consumes instruction.
REQ-015 inst  out  32  instruction word at buffer head.
REQ-016 inst_pc  out  32  PC of instruction at buffer head.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DROP; reset state IDLE; IDLE->REQ unconditionally on the first clock after reset release.
REQ-018 The block SHALL hold a 2-entry FIFO of {inst, pc} and allow at most one outstanding memory request.
REQ-019 In REQ, imem_req SHALL equal (count + 0 outstanding < 2) AND NOT redirect; imem_addr SHALL equal pc_cur combinationally.
REQ-020 On accept (imem_req AND imem_gnt), pc_ena SHALL be 1 and pc_next SHALL be pc_cur+4 mod 2^32 in the same cycle; req_pc latches pc_cur; state->WAIT.
REQ-021 In WAIT, imem_rvalid SHALL push {imem_rdata, req_pc} into the FIFO and return state->REQ; next request no earlier than the following cycle.
REQ-022 imem_rvalid SHALL be ignored in IDLE and REQ.
REQ-023 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL show the head entry; pop occurs on inst_valid AND inst_ready.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-025 Redirect SHALL take priority over all events: pc_ena=1, pc_next=redirect_pc, imem_req=0, FIFO count->0 on the next edge.
REQ-026 Redirect in WAIT without rvalid SHALL move to DROP; with rvalid that cycle, the data SHALL be discarded and state->REQ.
REQ-027 DROP SHALL discard the next rvalid then move to REQ; redirect in DROP SHALL stay in DROP.
REQ-028 Redirect in IDLE or REQ SHALL move to REQ with no request issued that cycle.
REQ-029 When neither accept nor redirect occurs, pc_ena SHALL be 0 and pc_next SHALL equal pc_cur.
REQ-030 Throughput with single-cycle gnt/rvalid and ready=1 SHALL be one instruction per 2 cycles.

Reset
REQ-031 rst=0 SHALL asynchronously force state IDLE, count 0, req_pc 0, drop flag 0; outputs imem_req=0, pc_ena=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the request; a later rvalid SHALL not be pushed.

Verification
REQ-033 Reset release, pc_cur=0x00400000, gnt=1 -> cycle 2 imem_req=1, addr 0x00400000, pc_ena=1, pc_next=0x00400004.
REQ-034 rvalid with rdata 0x8C010004 in WAIT, ready=1 -> next cycle inst_valid=1, inst=0x8C010004, inst_pc=0x00400000.
REQ-035 ready=0 for 10 cycles -> count reaches 2, imem_req stays 0, pc_ena stays 0, pc_cur unchanged.
REQ-036 Redirect to 0x00400100 in WAIT, rvalid one cycle later -> data discarded, inst_valid=0, next request addr 0x00400100.
REQ-037 pc_cur=0xFFFFFFFC accepted -> pc_next=0x00000000.
REQ-038 rst=0 while WAIT with count 1 -> all outputs 0 immediately; rvalid after release not pushed.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end. It issues one instruction-memory read at a
//   time from the current PC, advances the PC on each accepted request, and
//   buffers returned words with their PCs in a two-entry FIFO for decode.
//   A redirect flushes the FIFO, reloads the PC, and discards any response
//   still in flight.
//
// Ports
//   clk          in   rising-edge clock, shared with the PC register
//   rst          in   asynchronous active-low reset
//   pc_cur       in   current PC (PC register output)
//   pc_next      out  next PC (PC register data input)
//   pc_ena       out  PC register load enable
//   imem_req     out  instruction memory request
//   imem_addr    out  request address (always pc_cur)
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   read data valid
//   imem_rdata   in   read data
//   redirect     in   branch/jump/exception redirect pulse
//   redirect_pc  in   redirect target
//   inst_valid   out  an instruction is buffered for decode
//   inst_ready   in   decode consumes the head instruction
//   inst         out  instruction word at the FIFO head
//   inst_pc      out  PC of the instruction at the FIFO head
// -----------------------------------------------------------------------------
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_ena,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic        accept;
  logic        push;
  logic        pop;

  // ---------------------------------------------------------------------------
  // Request FSM and PC update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    pc_next  = pc_cur;
    pc_ena   = 1'b0;
    imem_req = 1'b0;
    accept   = 1'b0;
    push     = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // No request is in flight here, so only buffered entries limit issue.
        imem_req = (count_q < 2'd2) && !redirect;
        accept   = imem_req && imem_gnt;
        if (accept) begin
          pc_ena   = 1'b1;
          pc_next  = pc_cur + 32'd4;
          req_pc_d = pc_cur;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // A response racing a redirect belongs to the old path.
          push    = !redirect;
          state_d = REQ;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The in-flight response is stale; swallow it whether or not another
        // redirect arrives, otherwise nothing would ever leave this state.
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_ena  = 1'b1;
      pc_next = redirect_pc;
    end
  end

  assign imem_addr = pc_cur;

  // ---------------------------------------------------------------------------
  // Two-entry FIFO; entry 0 is always the head
  // ---------------------------------------------------------------------------
  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst0_q;
  assign inst_pc    = pc0_q;
  assign pop        = inst_valid && inst_ready;

  always_comb begin
    count_d = count_q;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;

    if (redirect) begin
      count_d = 2'd0;
    end else if (pop) begin
      inst0_d = inst1_q;
      pc0_d   = pc1_q;
      if (push) begin
        // Simultaneous push/pop: the new entry lands behind what remains.
        if (count_q == 2'd1) begin
          inst0_d = imem_rdata;
          pc0_d   = req_pc_q;
        end else begin
          inst1_d = imem_rdata;
          pc1_d   = req_pc_q;
        end
      end else begin
        count_d = count_q - 2'd1;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        inst0_d = imem_rdata;
        pc0_d   = req_pc_q;
      end else begin
        inst1_d = imem_rdata;
        pc1_d   = req_pc_q;
      end
      count_d = count_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      req_pc_q <= 32'd0;
      inst0_q  <= 32'd0;
      inst1_q  <= 32'd0;
      pc0_q    <= 32'd0;
      pc1_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      req_pc_q <= req_pc_d;
      inst0_q  <= inst0_d;
      inst1_q  <= inst1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        pc_set;
  logic [31:0] pc_set_val;

  int chk_cnt;
  int pass_cnt;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .pc_next     (pc_next),
    .pc_ena      (pc_ena),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register fed by the fetch unit; pc_set lets the bench plant a value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pc_cur <= 32'h0040_0000;
    else if (pc_set) pc_cur <= pc_set_val;
    else if (pc_ena) pc_cur <= pc_next;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    pc_set = 1'b0; pc_set_val = '0;

    #3;
    check("rst_req",   {31'd0, imem_req},   32'd0);
    check("rst_pcena", {31'd0, pc_ena},     32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",  inst,                32'd0);
    check("rst_instpc", inst_pc,            32'd0);

    cyc(); cyc();
    rst = 1'b1; imem_gnt = 1'b1; #1;
    // IDLE cycle: nothing issued, PC held
    check("idle_req",    {31'd0, imem_req}, 32'd0);
    check("idle_pcena",  {31'd0, pc_ena},   32'd0);
    check("idle_pcnext", pc_next,           32'h0040_0000);

    cyc();
    check("first_req",    {31'd0, imem_req}, 32'd1);
    check("first_addr",   imem_addr,         32'h0040_0000);
    check("first_pcena",  {31'd0, pc_ena},   32'd1);
    check("first_pcnext", pc_next,           32'h0040_0004);

    cyc();  // WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004; inst_ready = 1'b1; #1;
    check("wait_req",   {31'd0, imem_req}, 32'd0);
    check("wait_pcena", {31'd0, pc_ena},   32'd0);

    cyc();  // REQ, one entry buffered
    imem_rvalid = 1'b0; inst_ready = 1'b0; #1;
    check("push_valid",  {31'd0, inst_valid}, 32'd1);
    check("push_inst",   inst,                32'h8C01_0004);
    check("push_instpc", inst_pc,             32'h0040_0000);
    check("cnt1_req",    {31'd0, imem_req},   32'd1);
    check("cnt1_addr",   imem_addr,           32'h0040_0004);

    cyc();  // WAIT, count 1
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; #1;
    cyc();  // REQ, count 2
    imem_rvalid = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      check("full_req",   {31'd0, imem_req}, 32'd0);
      check("full_pcena", {31'd0, pc_ena},   32'd0);
      cyc();
    end
    check("full_pc",    pc_cur,              32'h0040_0008);
    check("full_valid", {31'd0, inst_valid}, 32'd1);

    inst_ready = 1'b1; imem_gnt = 1'b0; #1;
    check("pop0_inst", inst,    32'h8C01_0004);
    check("pop0_pc",   inst_pc, 32'h0040_0000);
    cyc();
    check("pop1_inst",  inst,                32'h1111_1111);
    check("pop1_pc",    inst_pc,             32'h0040_0004);
    check("pop1_valid", {31'd0, inst_valid}, 32'd1);
    cyc();
    inst_ready = 1'b0; #1;
    check("empty_valid", {31'd0, inst_valid}, 32'd0);

    imem_gnt = 1'b1; #1;
    check("req3_addr", imem_addr, 32'h0040_0008);
    cyc();  // WAIT
    redirect = 1'b1; redirect_pc = 32'h0040_0100; #1;
    check("redir_pcena",  {31'd0, pc_ena},   32'd1);
    check("redir_pcnext", pc_next,           32'h0040_0100);
    check("redir_req",    {31'd0, imem_req}, 32'd0);
    cyc();  // DROP
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("drop_req",   {31'd0, imem_req}, 32'd0);
    check("drop_pcena", {31'd0, pc_ena},   32'd0);
    cyc();  // REQ, stale data dropped
    imem_rvalid = 1'b0; #1;
    check("drop_valid",  {31'd0, inst_valid}, 32'd0);
    check("after_req",   {31'd0, imem_req},   32'd1);
    check("after_addr",  imem_addr,           32'h0040_0100);
    check("after_pcnxt", pc_next,             32'h0040_0104);

    cyc();  // WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; #1;
    cyc();  // REQ, count 1
    imem_rvalid = 1'b0; #1;
    cyc();  // WAIT, push and pop together
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0002; inst_ready = 1'b1; #1;
    cyc();
    imem_rvalid = 1'b0; inst_ready = 1'b0; #1;
    check("pp_valid",  {31'd0, inst_valid}, 32'd1);
    check("pp_inst",   inst,                32'hAAAA_0002);
    check("pp_instpc", inst_pc,             32'h0040_0104);
    check("pp_req",    {31'd0, imem_req},   32'd1);
    cyc();  // WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0003; #1;
    cyc();  // REQ, count 2
    imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0200; #1;
    check("flush_req",    {31'd0, imem_req}, 32'd0);
    check("flush_pcena",  {31'd0, pc_ena},   32'd1);
    check("flush_pcnext", pc_next,           32'h0040_0200);
    cyc();
    redirect = 1'b0; #1;
    check("flush_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_addr",  imem_addr,           32'h0040_0200);
    check("flush_req2",  {31'd0, imem_req},   32'd1);

    cyc();  // WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0001; #1;
    cyc();  // REQ, count 1
    imem_rvalid = 1'b0; #1;
    cyc();  // WAIT, count 1
    check("prerst_valid", {31'd0, inst_valid}, 32'd1);
    rst = 1'b0; #1;
    check("arst_req",    {31'd0, imem_req},   32'd0);
    check("arst_pcena",  {31'd0, pc_ena},     32'd0);
    check("arst_valid",  {31'd0, inst_valid}, 32'd0);
    check("arst_inst",   inst,                32'd0);
    check("arst_instpc", inst_pc,             32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0001;
    cyc();
    rst = 1'b1; imem_gnt = 1'b0; #1;
    cyc();  // REQ, stray rvalid still high
    check("stray_valid0", {31'd0, inst_valid}, 32'd0);
    cyc();
    check("stray_valid1", {31'd0, inst_valid}, 32'd0);
    imem_rvalid = 1'b0;

    pc_set = 1'b1; pc_set_val = 32'hFFFF_FFFC;
    cyc();
    pc_set = 1'b0; imem_gnt = 1'b1; #1;
    check("wrap_addr",   imem_addr,       32'hFFFF_FFFC);
    check("wrap_pcena",  {31'd0, pc_ena}, 32'd1);
    check("wrap_pcnext", pc_next,         32'h0000_0000);
    cyc();
    check("wrap_pc", pc_cur, 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
